instr_fetch_unit: RTL and testbench

- Fetch stage directly downstream of the PC register, and its only writer.
- Consumes PCOut and reads the instruction memory at that address over a req/ack handshake.
- Buffers fetched instructions, tagged with their PC, in a small FIFO for decode.
- Drives PCIn/PCWrite back to the PC register: sequential increment, or a redirect target from branch/jump resolution.

---
 rtl/instr_fetch_unit_pkg.sv | 27 ++
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/instr_fetch_unit_fifo.sv | 73 +++++++
 rtl/instr_fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared definitions for the instruction fetch unit: default
//            widths, FSM state encoding and the FIFO entry layout.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // FIFO entry layout: PC in the upper bits, instruction word in the lower
  // bits. Parameterised builds pack the same {pc, instr} order by hand.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Purpose  : Instruction memory read bus (req/ack handshake).
// Ports    : mem_req  - read request, held until mem_ack
//            mem_addr - read address, stable while mem_req is high
//            mem_ack  - read complete, mem_data valid this cycle
//            mem_data - read data
// Modports : master (fetch unit), slave (instruction memory)
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_data;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small instruction FIFO with synchronous push/pop/flush.
//            Flush has priority over push and pop.
// Ports    : Clock, Reset (async, active-high)
//            push/din   - write side
//            pop/dout   - read side, dout is the current head
//            flush      - empty the FIFO
//            count, full, empty - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  assign w_do_pop  = pop & ~empty & ~flush;
  // A push into a full FIFO is accepted only when a pop frees a slot.
  assign w_do_push = push & ~flush & (~full | w_do_pop);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: r_count gates every read of it.
  always_ff @(posedge Clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch stage. Reads instruction memory at PCOut, buffers
//            {pc, instr} pairs for decode and drives the PC register
//            (sequential increment or redirect target).
// Ports    : Clock, Reset (async, active-high)
//            PCOut / PCIn / PCWrite   - PC register interface
//            mem (master modport)     - instruction memory req/ack bus
//            instr_valid/instr_out/instr_pc/instr_ready - decode handshake
//            redirect/redirect_target - flush and load a new PC
// Options  : FETCH_BYPASS_EN - when defined, a word arriving while the FIFO
//            is empty is presented to decode in the ack cycle itself.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [ADDR_W-1:0]    PCOut,
  output logic [ADDR_W-1:0]    PCIn,
  output logic                 PCWrite,
  instr_fetch_unit_if.master   mem,
  output logic                 instr_valid,
  output logic [INSTR_W-1:0]   instr_out,
  output logic [ADDR_W-1:0]    instr_pc,
  input  logic                 instr_ready,
  input  logic                 redirect,
  input  logic [ADDR_W-1:0]    redirect_target
);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic                r_mem_req;
  logic                w_mem_req_nxt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic                w_pc_write;
  logic [ADDR_W-1:0]   w_pc_in;
  logic                w_flush;
  logic                w_fetch_hit;
  logic                w_bypass;
  logic                w_push;
  logic                w_pop;
  logic [ENTRY_W-1:0]  w_head;
  logic [CNT_W-1:0]    w_count;
  logic                w_full;
  logic                w_empty;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and PC update
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_pc_write     = 1'b0;
    w_pc_in        = '0;
    w_flush        = 1'b0;

    case (r_state)
      IDLE: begin
        if (redirect) begin
          w_pc_write = 1'b1;
          w_pc_in    = redirect_target;
          w_flush    = 1'b1;
        end else if (!w_full) begin
          w_mem_addr_nxt = PCOut;
          w_mem_req_nxt  = 1'b1;
          w_state_nxt    = WAIT;
        end
      end

      WAIT: begin
        if (mem.mem_ack) begin
          w_pc_write    = 1'b1;
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = IDLE;
          if (redirect) begin
            w_pc_in = redirect_target;
            w_flush = 1'b1;
          end else begin
            w_pc_in = r_mem_addr + ADDR_W'(1);
          end
        end else if (redirect) begin
          // The request stays up: memory must still complete it, and its
          // data is dropped in DISCARD.
          w_pc_write  = 1'b1;
          w_pc_in     = redirect_target;
          w_flush     = 1'b1;
          w_state_nxt = DISCARD;
        end
      end

      DISCARD: begin
        if (redirect) begin
          w_pc_write = 1'b1;
          w_pc_in    = redirect_target;
          w_flush    = 1'b1;
        end
        if (mem.mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end
      end

      default: begin
        w_mem_req_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO control and decode-side outputs
  // --------------------------------------------------------------------------
  assign w_fetch_hit = (r_state == WAIT) & mem.mem_ack & ~redirect;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_fetch_hit & w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word that decode takes immediately never enters the FIFO.
  assign w_push = w_fetch_hit & ~(w_bypass & instr_ready);
  assign w_pop  = ~w_empty & ~redirect & instr_ready;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   ({r_mem_addr, mem.mem_data}),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Combinational outputs are gated by Reset so they drop immediately,
  // not only once the registered state has cleared.
  assign instr_valid = ~Reset & (w_bypass | ((w_count != '0) & ~redirect));
  assign instr_out   = w_bypass ? mem.mem_data : w_head[INSTR_W-1:0];
  assign instr_pc    = w_bypass ? r_mem_addr   : w_head[ENTRY_W-1:INSTR_W];

  assign PCWrite = w_pc_write & ~Reset;
  assign PCIn    = Reset ? '0 : w_pc_in;

  assign mem.mem_req  = r_mem_req;
  assign mem.mem_addr = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit with a PC
//            register model and a one-cycle-latency memory returning
//            data = addr ^ 8'hA5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] PCOut;
  logic [7:0] PCIn;
  logic       PCWrite;
  logic       instr_valid;
  logic [7:0] instr_out;
  logic [7:0] instr_pc;
  logic       instr_ready;
  logic       redirect;
  logic [7:0] redirect_target;

  instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(8)) mem_bus ();

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .DEPTH(4)) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .PCOut           (PCOut),
    .PCIn            (PCIn),
    .PCWrite         (PCWrite),
    .mem             (mem_bus),
    .instr_valid     (instr_valid),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target)
  );

  always #5 Clock = ~Clock;

  // PC register model
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic [7:0] pc_reg;
  always @(posedge Clock) begin
    if (pc_load)      pc_reg <= pc_load_val;
    else if (PCWrite) pc_reg <= PCIn;
  end
  assign PCOut = pc_reg;

  // Memory model: ack the cycle after req is seen, while enabled
  logic mem_en;
  logic ack_r = 1'b0;
  always @(posedge Clock) ack_r <= mem_bus.mem_req & ~ack_r & mem_en;
  assign mem_bus.mem_ack  = ack_r;
  assign mem_bus.mem_data = ack_r ? (mem_bus.mem_addr ^ 8'hA5) : 8'h00;

  // Logs of accepted decode words and PC writes
  logic [15:0] pop_log[$];
  logic [7:0]  pcw_log[$];
  always @(negedge Clock) begin
    #2;
    if (instr_valid && instr_ready) pop_log.push_back({instr_pc, instr_out});
    if (PCWrite) pcw_log.push_back(PCIn);
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] pc);
    @(negedge Clock);
    Reset = 1'b1; redirect = 1'b0; instr_ready = 1'b0; mem_en = 1'b1;
    pc_load = 1'b1; pc_load_val = pc;
    @(negedge Clock);
    pc_load = 1'b0;
    pop_log.delete();
    pcw_log.delete();
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    redirect = 1'b0; redirect_target = 8'h00; instr_ready = 1'b0;
    mem_en = 1'b1; pc_load = 1'b1; pc_load_val = 8'h10;
    repeat (2) @(negedge Clock);

    // ---------------- reset state ----------------
    chk("rst_mem_req",     mem_bus.mem_req,  1'b0);
    chk("rst_mem_addr",    mem_bus.mem_addr, 8'h00);
    chk("rst_instr_valid", instr_valid,      1'b0);
    chk("rst_pcwrite",     PCWrite,          1'b0);
    chk("rst_pcin",        PCIn,             8'h00);

    // ---------------- sequential fetch ----------------
    start(8'h10);
    instr_ready = 1'b1;
    n = 0;
    while (!mem_bus.mem_ack && n < 20) begin @(negedge Clock); n++; end
    chk("t1_ack_seen", mem_bus.mem_ack, 1'b1);
    #1;
    chk("t1_pcwrite", PCWrite, 1'b1);
    chk("t1_pcin",    PCIn,    8'h11);
`ifdef FETCH_BYPASS_EN
    chk("t1_byp_valid", instr_valid, 1'b1);
    chk("t1_byp_out",   instr_out,   8'hB5);
    chk("t1_byp_pc",    instr_pc,    8'h10);
    @(negedge Clock);
    chk("t1_byp_next_valid", instr_valid, 1'b0);
`else
    chk("t1_lat_valid_ack", instr_valid, 1'b0);
    @(negedge Clock);
    chk("t1_lat_valid_next", instr_valid, 1'b1);
    chk("t1_lat_out",        instr_out,   8'hB5);
    chk("t1_lat_pc",         instr_pc,    8'h10);
`endif
    n = 0;
    while (pop_log.size() < 3 && n < 40) begin @(negedge Clock); n++; end
    chk("t1_pops_done", pop_log.size() >= 3, 1'b1);
    chk("t1_pop0", pop_log[0], 16'h10B5);
    chk("t1_pop1", pop_log[1], 16'h11B4);
    chk("t1_pop2", pop_log[2], 16'h12B7);
    chk("t1_pcw0", pcw_log[0], 8'h11);
    chk("t1_pcw1", pcw_log[1], 8'h12);
    chk("t1_pcw2", pcw_log[2], 8'h13);

    // ---------------- backpressure / full ----------------
    start(8'h10);
    repeat (40) @(negedge Clock);
    chk("t2_push_count", pcw_log.size(), 4);
    chk("t2_mem_req",    mem_bus.mem_req, 1'b0);
    chk("t2_pcout",      PCOut,           8'h14);
    chk("t2_valid",      instr_valid,     1'b1);
    chk("t2_head_pc",    instr_pc,        8'h10);
    chk("t2_head_instr", instr_out,       8'hB5);
    instr_ready = 1'b1;
    n = 0;
    while (!mem_bus.mem_req && n < 10) begin @(negedge Clock); n++; end
    chk("t2_resume_req",  mem_bus.mem_req,  1'b1);
    chk("t2_resume_addr", mem_bus.mem_addr, 8'h14);
    chk("t2_first_pop",   pop_log[0],       16'h10B5);

    // ---------------- redirect in WAIT before ack ----------------
    start(8'h10);
    instr_ready = 1'b1;
    mem_en = 1'b0;
    n = 0;
    while (!mem_bus.mem_req && n < 10) begin @(negedge Clock); n++; end
    chk("t3_req",  mem_bus.mem_req,  1'b1);
    chk("t3_addr", mem_bus.mem_addr, 8'h10);
    redirect = 1'b1; redirect_target = 8'h40;
    #1;
    chk("t3_pcwrite", PCWrite,     1'b1);
    chk("t3_pcin",    PCIn,        8'h40);
    chk("t3_valid",   instr_valid, 1'b0);
    @(negedge Clock);
    redirect = 1'b0; mem_en = 1'b1;
    #1;
    chk("t3_discard_req",   mem_bus.mem_req, 1'b1);
    chk("t3_valid_next",    instr_valid,     1'b0);
    chk("t3_pcout",         PCOut,           8'h40);
    chk("t3_pcwrite_after", PCWrite,         1'b0);
    n = 0;
    while (mem_bus.mem_req && n < 10) begin @(negedge Clock); n++; end
    chk("t3_req_drop", mem_bus.mem_req, 1'b0);
    n = 0;
    while (!mem_bus.mem_req && n < 10) begin @(negedge Clock); n++; end
    chk("t3_new_addr",  mem_bus.mem_addr, 8'h40);
    chk("t3_pcw_count", pcw_log.size(),   1);
    chk("t3_pcw0",      pcw_log[0],       8'h40);
    chk("t3_no_pop",    pop_log.size(),   0);

    // ---------------- redirect coincident with ack and pop ----------------
    start(8'h10);
    n = 0;
    while (!instr_valid && n < 10) begin @(negedge Clock); n++; end
    chk("t4_first_valid", instr_valid, 1'b1);
    n = 0;
    while (!mem_bus.mem_ack && n < 10) begin @(negedge Clock); n++; end
    chk("t4_ack_addr", mem_bus.mem_addr, 8'h11);
    redirect = 1'b1; redirect_target = 8'h80; instr_ready = 1'b1;
    #1;
    chk("t4_pcwrite", PCWrite,     1'b1);
    chk("t4_pcin",    PCIn,        8'h80);
    chk("t4_valid",   instr_valid, 1'b0);
    @(negedge Clock);
    redirect = 1'b0;
    #1;
    chk("t4_empty",   instr_valid,     1'b0);
    chk("t4_idle",    mem_bus.mem_req, 1'b0);
    chk("t4_no_pop",  pop_log.size(),  0);
    chk("t4_pcout",   PCOut,           8'h80);
    n = 0;
    while (!mem_bus.mem_req && n < 10) begin @(negedge Clock); n++; end
    chk("t4_new_addr", mem_bus.mem_addr, 8'h80);

    // ---------------- PC wrap-around ----------------
    start(8'hFF);
    instr_ready = 1'b1;
    n = 0;
    while (pop_log.size() < 2 && n < 30) begin @(negedge Clock); n++; end
    chk("t5_pops_done", pop_log.size() >= 2, 1'b1);
    chk("t5_pop0", pop_log[0], 16'hFF5A);
    chk("t5_pop1", pop_log[1], 16'h00A5);
    chk("t5_pcw0", pcw_log[0], 8'h00);

    // ---------------- asynchronous reset mid-WAIT ----------------
    start(8'h10);
    n = 0;
    while (!instr_valid && n < 10) begin @(negedge Clock); n++; end
    mem_en = 1'b0;
    n = 0;
    while (!mem_bus.mem_req && n < 10) begin @(negedge Clock); n++; end
    chk("t6_pre_req",   mem_bus.mem_req, 1'b1);
    chk("t6_pre_valid", instr_valid,     1'b1);
    #3;
    Reset = 1'b1;
    #1;
    chk("t6_req",      mem_bus.mem_req,  1'b0);
    chk("t6_addr",     mem_bus.mem_addr, 8'h00);
    chk("t6_valid",    instr_valid,      1'b0);
    chk("t6_pcwrite",  PCWrite,          1'b0);
    @(negedge Clock);
    Reset = 1'b0; mem_en = 1'b1;
    n = 0;
    while (!mem_bus.mem_req && n < 10) begin @(negedge Clock); n++; end
    chk("t6_restart_addr", mem_bus.mem_addr, 8'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
